// File: rtl/sfp_feeder.sv
// Layer-pass sequencer between psum SRAM, sfp_row and output SRAM: for each output pixel it
// clears sfp_row, streams K tap rows into it with acc asserted, then writes the ReLU'd row out.
module sfp_feeder #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int K       = 9,
    parameter int NUM_OUT = 16,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pmem_rd_en,
    output logic [addr_bw-1:0]       pmem_addr,
    input  logic [psum_bw*col-1:0]   pmem_rdata,
    output logic                     sfp_clr,
    output logic                     sfp_acc,
    output logic [psum_bw*col-1:0]   sfp_in,
    input  logic [psum_bw*col-1:0]   sfp_out,
    output logic                     omem_wr_en,
    output logic [addr_bw-1:0]       omem_addr,
    output logic [psum_bw*col-1:0]   omem_wdata
);

    localparam int T_W = (K > 1) ? $clog2(K) : 1;
    localparam int O_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [T_W-1:0] T_LAST = T_W'(K - 1);
    localparam logic [O_W-1:0] O_LAST = O_W'(NUM_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RD, S_LAST, S_SETTLE, S_WR, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [T_W-1:0]     r_t;
    logic [O_W-1:0]     r_o;
    logic               r_acc_p1;
    logic               w_rd_en;
    logic               w_wr_en;
    logic               w_last_tap;
    logic               w_last_pix;
    logic [addr_bw-1:0] w_addr;

    assign w_last_tap = (r_t == T_LAST);
    assign w_last_pix = (r_o == O_LAST);
    // Tile-major layout: all pixels of tap t are contiguous.
    assign w_addr = addr_bw'(r_t) * addr_bw'(NUM_OUT) + addr_bw'(r_o);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLR;
            S_CLR:    w_next = S_RD;
            S_RD:     if (w_last_tap) w_next = S_LAST;
            S_LAST:   w_next = S_SETTLE;
            S_SETTLE: w_next = S_WR;
            S_WR:     w_next = w_last_pix ? S_DONE : S_CLR;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        sfp_clr = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        case (r_state)
            S_IDLE:  busy    = 1'b0;
            S_CLR:   sfp_clr = 1'b1;
            S_RD:    w_rd_en = 1'b1;
            S_WR:    w_wr_en = 1'b1;
            S_DONE: begin
                done = 1'b1;
                busy = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_t <= '0;
            r_o <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_t <= '0;
                    r_o <= '0;
                end
                S_CLR:  r_t <= '0;
                S_RD:   if (!w_last_tap) r_t <= r_t + 1'b1;
                S_WR:   if (!w_last_pix) r_o <= r_o + 1'b1;
                default: ;
            endcase
        end
    end

    // rdata of the sync SRAM lands one cycle after rd_en, so acc tracks rd_en by one register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_p1 <= 1'b0;
        end else begin
            r_acc_p1 <= w_rd_en;
        end
    end

    assign pmem_rd_en = w_rd_en;
    assign pmem_addr  = w_rd_en ? w_addr : '0;
    assign sfp_acc    = r_acc_p1;
    assign sfp_in     = r_acc_p1 ? pmem_rdata : '0;
    assign omem_wr_en = w_wr_en;
    assign omem_addr  = w_wr_en ? addr_bw'(r_o) : '0;
    assign omem_wdata = w_wr_en ? sfp_out : '0;

endmodule

// File: tb/tb_sfp_feeder.sv
// Directed bench for sfp_feeder with behavioural psum SRAM and sfp_row models.
module tb_sfp_feeder;

    localparam int PB = 16;
    localparam int COL = 8;
    localparam int KK = 9;
    localparam int NO = 16;
    localparam int AW = 11;
    localparam int DW = PB * COL;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pmem_rd_en, sfp_clr, sfp_acc, omem_wr_en;
    logic [AW-1:0] pmem_addr, omem_addr;
    logic [DW-1:0] pmem_rdata, sfp_in, sfp_out, omem_wdata;

    sfp_feeder #(.psum_bw(PB), .col(COL), .K(KK), .NUM_OUT(NO), .addr_bw(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pmem_rd_en(pmem_rd_en), .pmem_addr(pmem_addr), .pmem_rdata(pmem_rdata),
        .sfp_clr(sfp_clr), .sfp_acc(sfp_acc), .sfp_in(sfp_in), .sfp_out(sfp_out),
        .omem_wr_en(omem_wr_en), .omem_addr(omem_addr), .omem_wdata(omem_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] pmem [0:KK*NO-1];
    always @(posedge clk) begin
        if (pmem_rd_en && pmem_addr < AW'(KK * NO)) pmem_rdata <= pmem[pmem_addr];
    end

    logic signed [PB-1:0] acc_m [COL];
    always @(posedge clk) begin
        for (int l = 0; l < COL; l++) begin
            if (sfp_clr) acc_m[l] <= '0;
            else if (sfp_acc) acc_m[l] <= acc_m[l] + $signed(sfp_in[l*PB +: PB]);
        end
    end
    always_comb begin
        sfp_out = '0;
        for (int l = 0; l < COL; l++) sfp_out[l*PB +: PB] = acc_m[l][PB-1] ? '0 : acc_m[l];
    end

    int            rd_cyc[$], wr_cyc[$], done_cyc[$], clr_cyc[$], b_rise[$], b_fall[$];
    logic [AW-1:0] rd_addr[$], wr_addr[$];
    logic [DW-1:0] wr_data[$];
    logic          busy_prev = 1'b0;
    int            viol = 0;

    always @(negedge clk) begin
        if (pmem_rd_en) begin rd_cyc.push_back(cyc); rd_addr.push_back(pmem_addr); end
        if (omem_wr_en) begin
            wr_cyc.push_back(cyc); wr_addr.push_back(omem_addr); wr_data.push_back(omem_wdata);
        end
        if (done) done_cyc.push_back(cyc);
        if (sfp_clr) clr_cyc.push_back(cyc);
        if (busy && !busy_prev) b_rise.push_back(cyc);
        if (!busy && busy_prev) b_fall.push_back(cyc);
        busy_prev = busy;
        if ((pmem_rd_en && omem_wr_en) || (sfp_clr && sfp_acc) || (done && busy) ||
            (!sfp_acc && sfp_in != '0) || (pmem_rd_en && pmem_addr >= AW'(KK * NO)))
            viol = viol + 1;
    end

    int n_assert = 0;
    int n_fail = 0;
    int t0 = 0;
    int nr, nw, nd, nc, nbr, nbf, v0;
    logic [DW-1:0] exp_row;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        nr = rd_cyc.size(); nw = wr_cyc.size(); nd = done_cyc.size();
        nc = clr_cyc.size(); nbr = b_rise.size(); nbf = b_fall.size(); v0 = viol;
    endtask

    task automatic start_pass();
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - t0 < n) tick();
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cyc.size() == nd && k < 400) begin tick(); k++; end
        chk({tag, "_done_seen"}, DW'(done_cyc.size() > nd), DW'(1));
    endtask

    task automatic fill_a();
        for (int t = 0; t < KK; t++)
            for (int o = 0; o < NO; o++) pmem[t*NO + o] = {COL{PB'(t + 1)}};
    endtask

    task automatic fill_b();
        for (int t = 0; t < KK; t++)
            for (int o = 0; o < NO; o++)
                for (int l = 0; l < COL; l++)
                    pmem[t*NO + o][l*PB +: PB] = (o == 0) ? -16'sd10 : (o == 1) ? 16'd2 : PB'(l + 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, DW'(busy), DW'(0));
        chk({tag, "_done"}, DW'(done), DW'(0));
        chk({tag, "_rd_en"}, DW'(pmem_rd_en), DW'(0));
        chk({tag, "_pmem_addr"}, DW'(pmem_addr), DW'(0));
        chk({tag, "_clr"}, DW'(sfp_clr), DW'(0));
        chk({tag, "_acc"}, DW'(sfp_acc), DW'(0));
        chk({tag, "_sfp_in"}, sfp_in, '0);
        chk({tag, "_wr_en"}, DW'(omem_wr_en), DW'(0));
        chk({tag, "_omem_addr"}, DW'(omem_addr), DW'(0));
        chk({tag, "_omem_wdata"}, omem_wdata, '0);
    endtask

    initial begin
        fill_a();
        repeat (3) tick();
        chk_outputs_zero("reset");
        reset = 1'b1;
        repeat (2) tick();

        // Pass A: uniform taps, timing, address order, start ignored while busy
        snap();
        start_pass();
        wait_rel(50);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("A");
        if (done_cyc.size() > nd) chk("A_done_cycle", DW'(done_cyc[nd] - t0), DW'(209));
        chk("A_done_count", DW'(done_cyc.size() - nd), DW'(1));
        if (clr_cyc.size() > nc) chk("A_first_clr", DW'(clr_cyc[nc] - t0), DW'(1));
        chk("A_rd_count", DW'(rd_cyc.size() - nr), DW'(KK * NO));
        chk("A_wr_count", DW'(wr_cyc.size() - nw), DW'(NO));
        if (rd_cyc.size() >= nr + KK * NO) begin
            chk("A_rd_first", DW'(rd_cyc[nr] - t0), DW'(2));
            chk("A_rd_ninth", DW'(rd_cyc[nr+8] - t0), DW'(10));
            chk("A_rd_pix1", DW'(rd_cyc[nr+9] - t0), DW'(15));
            for (int t = 0; t < KK; t++)
                chk($sformatf("A_addr_o3_t%0d", t), DW'(rd_addr[nr + 3*KK + t]), DW'(3 + 16*t));
        end
        if (wr_cyc.size() >= nw + NO) begin
            chk("A_wr_first", DW'(wr_cyc[nw] - t0), DW'(13));
            chk("A_wr_last", DW'(wr_cyc[nw+15] - t0), DW'(208));
            for (int i = 0; i < NO; i++) begin
                chk($sformatf("A_wr_addr%0d", i), DW'(wr_addr[nw+i]), DW'(i));
                chk($sformatf("A_wr_data%0d", i), wr_data[nw+i], {COL{16'd45}});
            end
        end
        if (b_rise.size() > nbr) chk("A_busy_rise", DW'(b_rise[nbr] - t0), DW'(1));
        if (b_fall.size() > nbf) chk("A_busy_fall", DW'(b_fall[nbf] - t0), DW'(209));
        chk("A_protocol", DW'(viol - v0), DW'(0));

        // Pass B: started the cycle after done; ReLU, clear between pixels, lane order
        fill_b();
        snap();
        start_pass();
        wait_done("B");
        if (done_cyc.size() > nd) chk("B_done_cycle", DW'(done_cyc[nd] - t0), DW'(209));
        chk("B_wr_count", DW'(wr_cyc.size() - nw), DW'(NO));
        if (wr_cyc.size() >= nw + NO) begin
            chk("B_row0_relu", wr_data[nw], '0);
            chk("B_row1_noleak", wr_data[nw+1], {COL{16'd18}});
            for (int l = 0; l < COL; l++) exp_row[l*PB +: PB] = PB'(9 * (l + 1));
            for (int i = 2; i < NO; i++) chk($sformatf("B_row%0d", i), wr_data[nw+i], exp_row);
        end
        chk("B_protocol", DW'(viol - v0), DW'(0));

        // Pass C: reset mid-RD aborts, then a fresh pass completes
        fill_a();
        repeat (2) tick();
        snap();
        start_pass();
        wait_rel(100);
        #1;
        reset = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        repeat (20) tick();
        chk("C_no_done", DW'(done_cyc.size() - nd), DW'(0));
        chk("C_partial_writes", DW'(wr_cyc.size() - nw), DW'(7));
        reset = 1'b1;
        tick();
        snap();
        start_pass();
        wait_done("C");
        if (done_cyc.size() > nd) chk("C_done_cycle", DW'(done_cyc[nd] - t0), DW'(209));
        chk("C_wr_count", DW'(wr_cyc.size() - nw), DW'(NO));
        if (wr_cyc.size() >= nw + NO)
            for (int i = 0; i < NO; i++) chk($sformatf("C_wr_data%0d", i), wr_data[nw+i], {COL{16'd45}});
        chk("C_protocol", DW'(viol - v0), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
